flash_peek_ctrl: RTL and testbench
==================================

Name: flash_peek_ctrl

Overview:
- Sequences an SPI-flash READ transaction and streams the returned bytes into the display register bank through its load/addr/data write port.
- Issues one command, one 24-bit address and NUM_BYTES data reads, with a one-cycle load strobe per received byte.
- Sits between the top level's flash pins (f_sclk/f_cs/f_mosi/f_miso) and the VGA driver's byte-register inputs.
- Started by a single-cycle pulse; reports busy/done.

Parameters:
- CLK_DIV, 4: clk cycles per f_sclk half-period; must be >= 2.
- NUM_BYTES, 8: bytes read per transaction; must be 1..2**ADDR_W.
- ADDR_W, 3: width of the register-bank address output.

Ports:
- clk  in  1  system clock; all logic on posedge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only while idle.
- base_addr  in  24  flash byte address; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse at transaction end.
- f_sclk  out  1  SPI clock, mode 0 (idle low).
- f_cs  out  1  chip select, active low.
- f_mosi  out  1  SPI data out, MSB first.
- f_miso  in  1  SPI data in.
- load  out  1  one-cycle write strobe to the register bank.
- addr  out  ADDR_W  register index for load.
- data  out  8  byte for load.

Behaviour:
- Reset values while n_rst is low: f_cs=1, f_sclk=0, f_mosi=0, load=0, addr=0, data=0, busy=0, done=0. The state machine goes to IDLE.
- State machine: IDLE -> CMD -> ADDR -> READ -> FINISH -> IDLE.
- IDLE: f_cs high. On start=1, latch base_addr, drive f_cs low and put the first command bit on f_mosi in the next cycle, then enter CMD.
- Bit timing:
  - f_sclk toggles every CLK_DIV clk cycles; each bit lasts 2*CLK_DIV cycles.
  - f_mosi updates on the clk edge that drives f_sclk low, and at CS assertion for the first bit.
  - f_miso is sampled on the clk edge that drives f_sclk high.
- CMD: shift out 8'h03.
- ADDR: shift out the latched address, bits 23..0.
- READ:
  - f_mosi is held 0; shift in NUM_BYTES bytes, MSB first.
  - On the cycle after the 8th sample of byte k: load=1, addr=k, data=that byte, for exactly one cycle. addr and data hold their values until the next load.
  - k runs 0..NUM_BYTES-1 with no wrap.
- FINISH:
  - After the last falling f_sclk edge, drive f_cs high and keep f_sclk low.
  - Hold f_cs high for CLK_DIV cycles (deselect time), then pulse done for one cycle and return to IDLE.
- Total f_cs-low time is (32 + 8*NUM_BYTES) * 2*CLK_DIV clk cycles.
- start asserted while busy is ignored, with no queuing. start in the same cycle as done is also ignored.
- Asserting n_rst mid-transaction aborts immediately: outputs take reset values, no further load pulses occur, and done is not pulsed.
- The bit counter and byte index are sized to cover 32 + 8*NUM_BYTES bits plus the optional dummy byte, with no overflow.

Optional Feature:
- Macro: FLASH_PEEK_CTRL_FAST_READ_EN.
- Defined:
  - The command is 8'h0B, and a DUMMY state inserted between ADDR and READ shifts 8 bits of 0 on f_mosi.
  - f_miso is ignored during DUMMY.
  - f_cs-low time grows by 8 bits (16*CLK_DIV cycles).
- Undefined: the command is 8'h03, there is no DUMMY state, and timing is as above.

Test Plan:
- Reset/idle: hold n_rst=0 for 5 cycles, then release -> f_cs=1, f_sclk=0, load=0, busy=0, done=0, and all hold with no start.
- Basic read (CLK_DIV=4, NUM_BYTES=8):
  - Stimulus: start with base_addr=24'h000010; flash model returns 8'hA0..8'hA7.
  - Required: MOSI bytes 03 00 00 10; eight load pulses with addr 0..7 and data A0..A7; f_cs low for exactly 768 cycles; a single done pulse after f_cs has been high for 4 cycles.
- Mode-0 timing: check every f_mosi transition occurs with f_sclk low, and that the f_miso sample matches the model bit at each rising edge.
- Busy rejection: pulse start 100 cycles into a transaction with base_addr=24'hFFFFFF -> the transaction is unaffected (address stays 000010), and exactly one done pulse occurs.
- Reset mid-ADDR: drop n_rst during the 10th address bit -> f_cs=1 next cycle, no load or done; after release, a fresh start with base_addr=24'h000020 completes normally.
- FAST_READ build: with the macro defined, the same stimulus as the basic read -> MOSI 0B 00 00 10 00; f_cs low for 832 cycles; same eight loads.

Source files
------------

// File: rtl/flash_peek_ctrl.sv
// SPI-flash READ sequencer that streams returned bytes into a register bank.
// Defining FLASH_PEEK_CTRL_FAST_READ_EN selects FAST READ (0x0B) with one dummy byte.
//
// state  | meaning
// IDLE   | f_cs high, waiting for start
// CMD    | shifting out the command byte
// ADDR   | shifting out the 24-bit address
// DUMMY  | FAST READ only: 8 zero bits, f_miso ignored
// READ   | shifting in NUM_BYTES bytes, one load strobe per byte
// FINISH | f_cs high for CLK_DIV cycles, then done
module flash_peek_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_BYTES = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [23:0]       base_addr,
  output logic              busy,
  output logic              done,
  output logic              f_sclk,
  output logic              f_cs,
  output logic              f_mosi,
  input  logic              f_miso,
  output logic              load,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

`ifdef FLASH_PEEK_CTRL_FAST_READ_EN
  localparam int         HDR_BITS = 40;
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam int         HDR_BITS = 32;
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
  localparam int NBITS = HDR_BITS + 8 * NUM_BYTES;
  localparam int BW    = $clog2(NBITS + 1);
  localparam int CW    = $clog2(CLK_DIV);
  localparam int BYW   = ADDR_W + 1;

  localparam logic [CW-1:0] DIV_LOAD      = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_ADDR      = BW'(8);
  localparam logic [BW-1:0] BIT_POST_ADDR = BW'(32);
  localparam logic [BW-1:0] BIT_READ      = BW'(HDR_BITS);
  localparam logic [BW-1:0] BIT_LAST      = BW'(NBITS);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, FINISH} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BYW-1:0]      byte_q, byte_d;
  logic [HDR_BITS-1:0] tx_q, tx_d;
  logic [7:0]          rx_q, rx_d;
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic                mosi_q, mosi_d;
  logic                load_q, load_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [HDR_BITS-1:0] tx_init;
  logic                tick;

  // The shift register doubles as the latched address; once emptied it feeds zeros.
`ifdef FLASH_PEEK_CTRL_FAST_READ_EN
  assign tx_init = {CMD_BYTE, base_addr, 8'h00};
`else
  assign tx_init = {CMD_BYTE, base_addr};
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    load_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q high means this is the done cycle: start is not accepted here.
        if (done_q) begin
          busy_d = 1'b0;
        end else if (start) begin
          state_d   = CMD;
          cs_d      = 1'b0;
          tx_d      = tx_init;
          mosi_d    = tx_init[HDR_BITS-1];
          cnt_d     = DIV_LOAD;
          bit_cnt_d = '0;
          byte_d    = '0;
          busy_d    = 1'b1;
        end
      end

      CMD, ADDR, DUMMY, READ: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = DIV_LOAD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (state_q == READ) begin
              rx_d = {rx_q[6:0], f_miso};
              if (bit_cnt_q[2:0] == 3'd7) begin
                load_d = 1'b1;
                addr_d = byte_q[ADDR_W-1:0];
                data_d = {rx_q[6:0], f_miso};
                byte_d = byte_q + 1'b1;
              end
            end
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = {tx_q[HDR_BITS-2:0], 1'b0};
            mosi_d    = tx_q[HDR_BITS-2];
            if (bit_cnt_d == BIT_LAST) begin
              state_d = FINISH;
              cs_d    = 1'b1;
              mosi_d  = 1'b0;
            end else if (bit_cnt_d == BIT_READ) begin
              state_d = READ;
`ifdef FLASH_PEEK_CTRL_FAST_READ_EN
            end else if (bit_cnt_d == BIT_POST_ADDR) begin
              state_d = DUMMY;
`endif
            end else if (bit_cnt_d == BIT_ADDR) begin
              state_d = ADDR;
            end
          end
        end
      end

      FINISH: begin
        if (tick) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      byte_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign f_sclk = sclk_q;
  assign f_cs   = cs_q;
  assign f_mosi = mosi_q;
  assign load   = load_q;
  assign addr   = addr_q;
  assign data   = data_q;

endmodule

// File: tb/tb_flash_peek_ctrl.sv
// Bench for flash_peek_ctrl: behavioural SPI flash with random memory, header
// capture, load scoreboard and timing measurement. Honours FLASH_PEEK_CTRL_FAST_READ_EN.
module tb_flash_peek_ctrl;
  localparam int CLK_DIV = 4;
  localparam int NB      = 8;
  localparam int AW      = 3;
`ifdef FLASH_PEEK_CTRL_FAST_READ_EN
  localparam int HDR = 40;
`else
  localparam int HDR = 32;
`endif
  localparam int CS_LOW_EXP = (HDR + 8 * NB) * 2 * CLK_DIV;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [23:0]   base_addr;
  logic          busy, done, f_sclk, f_cs, f_mosi, load;
  logic          f_miso = 1'b0;
  logic [AW-1:0] addr;
  logic [7:0]    data;

  flash_peek_ctrl #(.CLK_DIV(CLK_DIV), .NUM_BYTES(NB), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .f_sclk(f_sclk), .f_cs(f_cs), .f_mosi(f_mosi),
    .f_miso(f_miso), .load(load), .addr(addr), .data(data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash memory image (64 bytes, address aliased modulo 64)
  logic [7:0] mem [64];

  // Monitor / flash model state, written only by the monitor process
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int          cs_cnt = 0, cs_low_len = 0, rise_cnt = 0;
  int          since = 0, armed = 0, done_delay = -1;
  int          done_total = 0, load_total = 0, mode0_bad = 0, ld_n = 0;
  logic [39:0] hdr = '0;
  logic [23:0] faddr;
  logic [7:0]  mon_b;
  int          mon_off;
  logic [AW-1:0] ld_addr [16];
  logic [7:0]    ld_data [16];

  always @(negedge clk) begin
    if (f_mosi !== prev_mosi && f_sclk !== 1'b0) mode0_bad++;
    if (f_cs === 1'b0 && prev_cs === 1'b1) begin
      cs_cnt = 0; rise_cnt = 0; hdr = '0; ld_n = 0; armed = 0;
      f_miso = 1'($urandom);
    end
    if (f_cs === 1'b0) begin
      cs_cnt++;
      if (f_sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (rise_cnt < HDR) hdr = {hdr[38:0], f_mosi};
        rise_cnt++;
      end
      if (f_sclk === 1'b0 && prev_sclk === 1'b1) begin
        if (rise_cnt >= HDR) begin
`ifdef FLASH_PEEK_CTRL_FAST_READ_EN
          faddr = hdr[31:8];
`else
          faddr = hdr[23:0];
`endif
          mon_off = rise_cnt - HDR;
          mon_b   = mem[(int'(faddr) + mon_off / 8) % 64];
          f_miso  = mon_b[7 - (mon_off % 8)];
        end else begin
          f_miso = 1'($urandom);  // junk during command/address/dummy
        end
      end
    end
    if (f_cs === 1'b1 && prev_cs === 1'b0) begin
      cs_low_len = cs_cnt; since = 0; armed = 1;
    end else if (armed != 0) begin
      since++;
    end
    if (done === 1'b1) begin
      done_total++;
      if (armed != 0) done_delay = since;
      armed = 0;
    end
    if (load === 1'b1) begin
      load_total++;
      if (ld_n < 16) begin
        ld_addr[ld_n] = addr;
        ld_data[ld_n] = data;
      end
      ld_n++;
    end
    prev_cs = f_cs; prev_sclk = f_sclk; prev_mosi = f_mosi;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [23:0] a, input bit poke_busy);
    int dn0, ld0, cyc, idx;
    logic [39:0] exp_hdr;
`ifdef FLASH_PEEK_CTRL_FAST_READ_EN
    exp_hdr = {8'h0B, a, 8'h00};
`else
    exp_hdr = {8'h00, 8'h03, a};
`endif
    dn0 = done_total;
    ld0 = load_total;
    base_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 24'($urandom);
    check_eq("busy_after_start", 64'(busy), 64'(1));
    check_eq("cs_after_start", 64'(f_cs), 64'(0));
    cyc = 0;
    while (done_total == dn0 && cyc < 5000) begin
      tick();
      cyc++;
      if (poke_busy && cyc == 100) begin
        base_addr = 24'hFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc++;
        check_eq("busy_during_poke", 64'(busy), 64'(1));
      end
    end
    check_eq("done_timeout", 64'(cyc < 5000), 64'(1));
    repeat (3) tick();
    check_eq("done_count", 64'(done_total - dn0), 64'(1));
    check_eq("busy_after_done", 64'(busy), 64'(0));
    check_eq("cs_after_done", 64'(f_cs), 64'(1));
    check_eq("mosi_header", 64'(hdr), 64'(exp_hdr));
    check_eq("cs_low_cycles", 64'(cs_low_len), 64'(CS_LOW_EXP));
    check_eq("deselect_to_done", 64'(done_delay), 64'(CLK_DIV));
    check_eq("load_count", 64'(load_total - ld0), 64'(NB));
    for (int k = 0; k < NB; k++) begin
      idx = (int'(a) + k) % 64;
      check_eq("load_addr", 64'(ld_addr[k]), 64'(k));
      check_eq("load_data", 64'(ld_data[k]), 64'(mem[idx]));
    end
    idx = (int'(a) + NB - 1) % 64;
    check_eq("addr_hold", 64'(addr), 64'(NB - 1));
    check_eq("data_hold", 64'(data), 64'(mem[idx]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn0, ld0, cyc;
    n_rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'hA0 + 8'(i);

    repeat (5) tick();
    check_eq("rst_cs", 64'(f_cs), 64'(1));
    check_eq("rst_sclk", 64'(f_sclk), 64'(0));
    check_eq("rst_mosi", 64'(f_mosi), 64'(0));
    check_eq("rst_load", 64'(load), 64'(0));
    check_eq("rst_addr", 64'(addr), 64'(0));
    check_eq("rst_data", 64'(data), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    n_rst = 1'b1;
    repeat (10) tick();
    check_eq("idle_cs", 64'(f_cs), 64'(1));
    check_eq("idle_sclk", 64'(f_sclk), 64'(0));
    check_eq("idle_busy", 64'(busy), 64'(0));
    check_eq("idle_loads", 64'(load_total), 64'(0));
    check_eq("idle_dones", 64'(done_total), 64'(0));

    // Basic read with a rejected start mid-transaction
    run_txn(24'h000010, 1'b1);

    // Random memory contents and base addresses
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      repeat (int'($urandom_range(1, 20))) tick();
      run_txn(24'($urandom), 1'b0);
    end

    // Reset during the 10th address bit (overall bit index 17)
    dn0 = done_total;
    ld0 = load_total;
    base_addr = 24'h000010;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (rise_cnt < 18 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_eq("reach_addr_bit", 64'(cyc < 2000), 64'(1));
    n_rst = 1'b0;
    tick();
    check_eq("abort_cs", 64'(f_cs), 64'(1));
    check_eq("abort_sclk", 64'(f_sclk), 64'(0));
    check_eq("abort_busy", 64'(busy), 64'(0));
    repeat (4) tick();
    n_rst = 1'b1;
    repeat (CS_LOW_EXP) tick();
    check_eq("abort_no_load", 64'(load_total - ld0), 64'(0));
    check_eq("abort_no_done", 64'(done_total - dn0), 64'(0));
    check_eq("abort_idle_cs", 64'(f_cs), 64'(1));

    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    run_txn(24'h000020, 1'b0);

    check_eq("mode0_mosi_changes", 64'(mode0_bad), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
